count_display_hour: RTL and testbench

Hours stage of the digital clock, directly downstream of the minutes counter. Consumes the minutes terminal-count signal as its carry. Also handles manual hour setting. Keeps hours 0..N-1 and drives two active-low 7-segment digits (ones, tens). Emits a day-carry pulse for any later date stage.

---
 rtl/clock_pkg.sv | 49 ++++
 rtl/seg7_encode.sv | 34 +++
 rtl/count_display_hour.sv | 206 ++++++++++++++++++++
 tb/tb_count_display_hour.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital-clock counter stages (seconds, minutes,
// hours).
//
// Contents:
//   SEG_0 .. SEG_9   active-low 7-segment codes, bit order {a,b,c,d,e,f,g}
//   SEG_BLANK        all segments off
//   DIGIT_BLANK      digit value that seg7_encode renders as SEG_BLANK
//   DEFAULT_SET_DIV  set-button auto-repeat period at a 50 MHz clock (1 s)
//   DEFAULT_CW       prescaler width large enough for DEFAULT_SET_DIV
//   hour_to_12h()    maps a 0..23 hour onto the 1..12 face of a 12-hour clock
// -----------------------------------------------------------------------------
package clock_pkg;

  // Active-low segment patterns, MSB = segment a, LSB = segment g.
  localparam logic [6:0] SEG_0     = 7'b000_0001;
  localparam logic [6:0] SEG_1     = 7'b100_1111;
  localparam logic [6:0] SEG_2     = 7'b001_0010;
  localparam logic [6:0] SEG_3     = 7'b000_0110;
  localparam logic [6:0] SEG_4     = 7'b100_1100;
  localparam logic [6:0] SEG_5     = 7'b010_0100;
  localparam logic [6:0] SEG_6     = 7'b010_0000;
  localparam logic [6:0] SEG_7     = 7'b000_1111;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b000_0100;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Any digit code above 9 is drawn blank; this one is used on purpose.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // One auto-increment per second of holding the set button at 50 MHz.
  localparam int DEFAULT_SET_DIV = 50_000_000;
  localparam int DEFAULT_CW      = 26;

  // 0 -> 12, 1..12 unchanged, 13..23 -> 1..11.
  function automatic logic [4:0] hour_to_12h(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0) begin
      r = 5'd12;
    end else if (h > 5'd12) begin
      r = h - 5'd12;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
// Combinational BCD digit to active-low 7-segment decoder. Shared by all
// counter stages of the clock.
//
// Ports:
//   digit  in  4  digit value; 0..9 decoded, anything else drawn blank
//   seg    out 7  segments {a..g}, active-low
// -----------------------------------------------------------------------------
module seg7_encode
  import clock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_hour.sv
// -----------------------------------------------------------------------------
// count_display_hour
// Hours stage of the digital clock. Advances once per rising edge of the
// minutes terminal count, or at a fixed auto-repeat rate while the set button
// is held. Drives two active-low 7-segment digits and a day-carry pulse.
//
// Parameters:
//   N        hour modulus (wraps N-1 -> 0)
//   SET_DIV  clk cycles per auto-increment while add_hour is held
//   CW       prescaler width, 2**CW >= SET_DIV
//
// Ports:
//   clk        in  1  system clock
//   reset      in  1  asynchronous reset, active low
//   carry_in   in  1  minutes terminal count (level, may stay high for long)
//   add_hour   in  1  manual set button (level, synchronised)
//   stopwatch  in  1  stopwatch view active; hour digits blanked
//   display    out 7  ones digit segments {a..g}, active-low
//   display10  out 7  tens digit segments {a..g}, active-low
//   tc         out 1  one-cycle day carry on a carry-driven N-1 -> 0 wrap
//   hour       out 5  binary hour 0..N-1
//   pm         out 1  hour >= 12 (only with HOUR_12H_DISPLAY_EN)
//
// Build option:
//   HOUR_12H_DISPLAY_EN  when defined, the digits show 12-hour format with a
//                        blanked leading zero and the pm output is added. The
//                        hour count, hour port and tc stay 24-hour.
// -----------------------------------------------------------------------------
module count_display_hour
  import clock_pkg::*;
#(
  parameter int N       = 24,
  parameter int SET_DIV = DEFAULT_SET_DIV,
  parameter int CW      = DEFAULT_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       carry_in,
  input  logic       add_hour,
  input  logic       stopwatch,
  output logic [6:0] display,
  output logic [6:0] display10,
  output logic       tc,
  output logic [4:0] hour
`ifdef HOUR_12H_DISPLAY_EN
  ,
  output logic       pm
`endif
);

  localparam logic [CW-1:0] PRESC_LAST = CW'(SET_DIV - 1);
  localparam logic [4:0]    HOUR_LAST  = 5'(N - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          carry_d_reg;
  logic [CW-1:0] presc_reg;
  logic [CW-1:0] presc_next;
  logic [4:0]    hour_reg;
  logic [4:0]    hour_next;
  logic          tc_reg;
  logic          tc_next;
  logic [6:0]    display_reg;
  logic [6:0]    display_next;
  logic [6:0]    display10_reg;
  logic [6:0]    display10_next;

  // ---------------------------------------------------------------------------
  // Increment sources
  // ---------------------------------------------------------------------------
  logic inc_c;
  logic inc_s;
  logic inc;
  logic presc_done;
  logic at_last;

  always_comb begin
    // A long carry_in level must only count once: act on its rising edge.
    inc_c      = carry_in & ~carry_d_reg;
    presc_done = (presc_reg == PRESC_LAST);
    inc_s      = add_hour & presc_done;

    // Prescaler sits at zero while the button is released, so the first
    // set increment always lands a full SET_DIV cycles after the press.
    presc_next = '0;
    if (add_hour && !presc_done) begin
      presc_next = presc_reg + 1'b1;
    end

    // Holding the set button masks the minutes carry entirely.
    inc     = add_hour ? inc_s : inc_c;
    at_last = (hour_reg == HOUR_LAST);

    hour_next = hour_reg;
    if (inc) begin
      hour_next = at_last ? 5'd0 : hour_reg + 5'd1;
    end

    // Only a carry-driven wrap propagates to the next stage; setting the
    // hour by hand must not advance the date.
    tc_next = inc_c & ~add_hour & at_last;
  end

  // ---------------------------------------------------------------------------
  // Digit split, computed from hour_next so the segments change on the same
  // edge as the hour register.
  // ---------------------------------------------------------------------------
  logic [4:0] shown_hour;
  logic [3:0] digit_val [2];   // [0] ones, [1] tens
  logic [6:0] digit_seg [2];

`ifdef HOUR_12H_DISPLAY_EN
  logic pm_reg;
  logic pm_next;

  always_comb begin
    shown_hour = hour_to_12h(hour_next);
    pm_next    = (hour_next >= 5'd12);
  end
`else
  always_comb begin
    shown_hour = hour_next;
  end
`endif

  // Tens/ones by range compare: the hour never exceeds 31, so at most three
  // subtraction bands are needed and no divider is inferred.
  always_comb begin
    digit_val[0] = 4'd0;
    digit_val[1] = 4'd0;
    if (shown_hour >= 5'd30) begin
      digit_val[1] = 4'd3;
      digit_val[0] = 4'(shown_hour - 5'd30);
    end else if (shown_hour >= 5'd20) begin
      digit_val[1] = 4'd2;
      digit_val[0] = 4'(shown_hour - 5'd20);
    end else if (shown_hour >= 5'd10) begin
      digit_val[1] = 4'd1;
      digit_val[0] = 4'(shown_hour - 5'd10);
    end else begin
      digit_val[1] = 4'd0;
      digit_val[0] = 4'(shown_hour);
    end
`ifdef HOUR_12H_DISPLAY_EN
    // A 12-hour face has no leading zero.
    if (digit_val[1] == 4'd0) begin
      digit_val[1] = DIGIT_BLANK;
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      seg7_encode u_seg7 (
        .digit (digit_val[gi]),
        .seg   (digit_seg[gi])
      );
    end
  endgenerate

  // Stopwatch view blanks the digits only; counting carries on underneath.
  always_comb begin
    display_next   = stopwatch ? SEG_BLANK : digit_seg[0];
    display10_next = stopwatch ? SEG_BLANK : digit_seg[1];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_d_reg   <= 1'b0;
      presc_reg     <= '0;
      hour_reg      <= 5'd0;
      tc_reg        <= 1'b0;
      display_reg   <= SEG_0;
      display10_reg <= SEG_0;
    end else begin
      carry_d_reg   <= carry_in;
      presc_reg     <= presc_next;
      hour_reg      <= hour_next;
      tc_reg        <= tc_next;
      display_reg   <= display_next;
      display10_reg <= display10_next;
    end
  end

`ifdef HOUR_12H_DISPLAY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pm_reg <= 1'b0;
    end else begin
      pm_reg <= pm_next;
    end
  end

  assign pm = pm_reg;
`endif

  assign hour      = hour_reg;
  assign tc        = tc_reg;
  assign display   = display_reg;
  assign display10 = display10_reg;

endmodule

// File: tb/tb_count_display_hour.sv
// -----------------------------------------------------------------------------
// tb_count_display_hour
// Directed scenarios followed by random stimulus, every cycle compared with a
// behavioural model of the hours counter kept in integers.
// -----------------------------------------------------------------------------
module tb_count_display_hour;

  localparam int N       = 24;
  localparam int SET_DIV = 4;
  localparam int CW      = 3;

  localparam logic [6:0] S_BLANK = 7'b111_1111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       carry_in = 1'b0;
  logic       add_hour = 1'b0;
  logic       stopwatch = 1'b0;
  logic [6:0] display;
  logic [6:0] display10;
  logic       tc;
  logic [4:0] hour;
`ifdef HOUR_12H_DISPLAY_EN
  logic       pm;
`endif

  always #5 clk = ~clk;

  count_display_hour #(
    .N       (N),
    .SET_DIV (SET_DIV),
    .CW      (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .carry_in  (carry_in),
    .add_hour  (add_hour),
    .stopwatch (stopwatch),
    .display   (display),
    .display10 (display10),
    .tc        (tc),
    .hour      (hour)
`ifdef HOUR_12H_DISPLAY_EN
    ,
    .pm        (pm)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Segment table, digits 0..9.
  logic [6:0] seg_tab [10] = '{7'b000_0001, 7'b100_1111, 7'b001_0010,
                               7'b000_0110, 7'b100_1100, 7'b010_0100,
                               7'b010_0000, 7'b000_1111, 7'b000_0000,
                               7'b000_0100};

  // Model state
  int m_hour     = 0;
  bit m_tc       = 0;
  bit m_prev_car = 0;
  int m_held     = 0;   // consecutive cycles the set button has been held
  bit m_blank    = 0;
  bit m_in_reset = 1;   // digits still show the reset pattern

  function automatic logic [6:0] seg_of(input int d);
    if (d >= 0 && d <= 9) return seg_tab[d];
    return S_BLANK;
  endfunction

  function automatic int face_hour();
`ifdef HOUR_12H_DISPLAY_EN
    if (m_hour == 0) return 12;
    if (m_hour > 12) return m_hour - 12;
`endif
    return m_hour;
  endfunction

  function automatic logic [6:0] exp_ones();
    if (m_in_reset) return seg_tab[0];
    if (m_blank) return S_BLANK;
    return seg_of(face_hour() % 10);
  endfunction

  function automatic logic [6:0] exp_tens();
    if (m_in_reset) return seg_tab[0];
    if (m_blank) return S_BLANK;
`ifdef HOUR_12H_DISPLAY_EN
    if (face_hour() / 10 == 0) return S_BLANK;
`endif
    return seg_of(face_hour() / 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hour = 0; m_tc = 0; m_prev_car = 0; m_held = 0;
    m_blank = 0; m_in_reset = 1;
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge(input bit r, input bit ci, input bit ah,
                            input bit sw);
    bit inc;
    if (!r) begin
      model_reset();
      return;
    end
    inc  = 0;
    m_tc = 0;
    if (ah) begin
      m_held++;
      if (m_held % SET_DIV == 0) inc = 1;
    end else begin
      m_held = 0;
      if (ci && !m_prev_car) begin
        inc = 1;
        if (m_hour == N - 1) m_tc = 1;
      end
    end
    m_prev_car = ci;
    if (inc) m_hour = (m_hour + 1) % N;
    m_blank    = sw;
    m_in_reset = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".hour"},      32'(hour),      32'(m_hour));
    check({tag, ".tc"},        32'(tc),        32'(m_tc));
    check({tag, ".display"},   32'(display),   32'(exp_ones()));
    check({tag, ".display10"}, 32'(display10), 32'(exp_tens()));
`ifdef HOUR_12H_DISPLAY_EN
    check({tag, ".pm"},        32'(pm),        32'(m_hour >= 12));
`endif
    $display("step t=%0t %s rst=%0b ci=%0b ah=%0b sw=%0b hour=%0d tc=%0b d=%b d10=%b",
             $time, tag, reset, carry_in, add_hour, stopwatch, hour, tc,
             display, display10);
  endtask

  // One clock: inputs sampled at the edge, outputs checked 1 ns later.
  task automatic step(input string tag);
    bit r, ci, ah, sw;
    r = reset; ci = carry_in; ah = add_hour; sw = stopwatch;
    @(posedge clk);
    model_edge(r, ci, ah, sw);
    #1;
    compare_all(tag);
  endtask

  task automatic carry_pulses(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      carry_in = 1'b1; step(tag);
      carry_in = 1'b0; step(tag);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, ".async_hour"}, 32'(hour),      32'd0);
    check({tag, ".async_tc"},   32'(tc),        32'd0);
    check({tag, ".async_d"},    32'(display),   32'(7'b000_0001));
    check({tag, ".async_d10"},  32'(display10), 32'(7'b000_0001));
    step(tag);
    reset = 1'b1;
  endtask

  initial begin
    // Power-up reset
    reset = 1'b0;
    step("por");
    step("por");
    reset = 1'b1;

    // 1. Reset in the middle of a set hold at hour 7
    carry_pulses(7, "t1_pre");
    check("t1_hour7", 32'(hour), 32'd7);
    add_hour = 1'b1;
    step("t1_hold");
    step("t1_hold");
    async_reset("t1");
    // Prescaler must restart: next set increment 4 edges after release
    for (int i = 1; i <= SET_DIV; i++) begin
      step("t1_after");
      if (i == SET_DIV - 1) check("t1_not_yet", 32'(hour), 32'd0);
    end
    check("t1_first_set", 32'(hour), 32'd1);
    add_hour = 1'b0;
    step("t1_rel");

    // 2. Long carry level gives a single increment
    async_reset("t2_rst");
    carry_in = 1'b1;
    step("t2");
    check("t2_hour1", 32'(hour), 32'd1);
`ifndef HOUR_12H_DISPLAY_EN
    check("t2_d",   32'(display),   32'(7'b100_1111));
    check("t2_d10", 32'(display10), 32'(7'b000_0001));
`endif
    for (int i = 1; i < 100; i++) step("t2_level");
    carry_in = 1'b0;
    step("t2_low");
    check("t2_still1", 32'(hour), 32'd1);

    // 3. Carry wrap 23 -> 0 with a one-cycle tc
    async_reset("t3_rst");
    carry_pulses(23, "t3_pre");
    check("t3_hour23", 32'(hour), 32'd23);
`ifndef HOUR_12H_DISPLAY_EN
    check("t3_d23",   32'(display),   32'(7'b000_0110));
    check("t3_d10_23", 32'(display10), 32'(7'b001_0010));
`endif
    carry_in = 1'b1;
    step("t3_wrap");
    check("t3_hour0", 32'(hour), 32'd0);
    check("t3_tc1",   32'(tc),   32'd1);
    step("t3_after");
    check("t3_tc0",   32'(tc),   32'd0);
    carry_in = 1'b0;
    step("t3_low");

    // 4. Manual set from 22 with carry toggling underneath
    async_reset("t4_rst");
    carry_pulses(22, "t4_pre");
    add_hour = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      carry_in = ~carry_in;
      step("t4_set");
      check("t4_no_tc", 32'(tc), 32'd0);
      if (i == 4)  check("t4_c4",  32'(hour), 32'd23);
      if (i == 8)  check("t4_c8",  32'(hour), 32'd0);
      if (i == 12) check("t4_c12", 32'(hour), 32'd1);
    end
    add_hour = 1'b0;
    carry_in = 1'b0;
    step("t4_rel");

    // 5. Stopwatch view blanks digits, counting continues
    async_reset("t5_rst");
    carry_pulses(5, "t5_pre");
    stopwatch = 1'b1;
    step("t5_view");
    check("t5_blank",   32'(display),   32'(S_BLANK));
    check("t5_blank10", 32'(display10), 32'(S_BLANK));
    carry_pulses(1, "t5_carry");
    check("t5_hour6", 32'(hour), 32'd6);
    stopwatch = 1'b0;
    step("t5_back");
    check("t5_d6", 32'(display), 32'(7'b010_0000));
`ifndef HOUR_12H_DISPLAY_EN
    check("t5_d10_0", 32'(display10), 32'(7'b000_0001));
`endif

`ifdef HOUR_12H_DISPLAY_EN
    // 6. 12-hour face
    async_reset("t6_rst");
    check("t6_h0_pm", 32'(pm), 32'd0);
    step("t6_h0");
    check("t6_h0_d",   32'(display),   32'(7'b001_0010));
    check("t6_h0_d10", 32'(display10), 32'(7'b100_1111));
    carry_pulses(12, "t6_pre12");
    check("t6_h12_d",   32'(display),   32'(7'b001_0010));
    check("t6_h12_d10", 32'(display10), 32'(7'b100_1111));
    check("t6_h12_pm",  32'(pm), 32'd1);
    carry_pulses(1, "t6_pre13");
    check("t6_h13_d",   32'(display),   32'(7'b100_1111));
    check("t6_h13_d10", 32'(display10), 32'(S_BLANK));
    check("t6_h13_pm",  32'(pm), 32'd1);
`endif

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0)   carry_in  = ~carry_in;
      if ($urandom_range(19) == 0)  add_hour  = ~add_hour;
      if ($urandom_range(29) == 0)  stopwatch = ~stopwatch;
      reset = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
